// File: rtl/fifo_rd_packer.sv
// Drains a SyncFIFO and packs RATIO consecutive words into one valid/ready output beat.
// A flush pulse pushes out whatever partial pack is held once the in-flight read lands.
module fifo_rd_packer #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned RATIO = 2,
  localparam int unsigned CntW = $clog2(RATIO + 1)
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,
  input  logic                   fifo_empty,
  output logic                   fifo_rden,
  input  logic [WIDTH-1:0]       fifo_rddata,
  input  logic                   flush,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [WIDTH*RATIO-1:0] m_data,
  output logic [CntW-1:0]        m_cnt,
  output logic                   busy
);

  localparam int unsigned OccW = CntW + 1;

  typedef enum logic [0:0] {StRun, StFlush} state_e;

  state_e                          state_q, state_d;
  logic [RATIO-1:0][WIDTH-1:0]     pack_q, pack_d;
  logic [CntW-1:0]                 pack_cnt_q, pack_cnt_d;
  logic                            inflight_q, inflight_d;
  logic                            m_valid_q, m_valid_d;
  logic [WIDTH*RATIO-1:0]          m_data_q, m_data_d;
  logic [CntW-1:0]                 m_cnt_q, m_cnt_d;

  logic            out_free;
  logic            xfer;
  logic            flush_emit;
  logic            emit;
  logic [OccW-1:0] occ;
  logic [CntW-1:0] slot;

  always_comb begin
    out_free   = !m_valid_q || m_ready;
    xfer       = (pack_cnt_q == CntW'(RATIO)) && out_free;
    flush_emit = (state_q == StFlush) && !inflight_q && (pack_cnt_q != '0) && out_free;
    emit       = xfer || flush_emit;

    // Counting the in-flight word keeps a full pack from ever having a read behind it.
    occ = OccW'(pack_cnt_q) + OccW'(inflight_q) - (xfer ? OccW'(RATIO) : OccW'(0));
    fifo_rden = sys_rst_n && !fifo_empty && (state_q == StRun) && (occ < OccW'(RATIO));

    inflight_d = fifo_rden;

    // Emitting clears the pack so unused slots of a partial beat read as zero.
    pack_d = emit ? '0 : pack_q;
    slot   = emit ? '0 : pack_cnt_q;
    if (inflight_q) begin
      for (int unsigned i = 0; i < RATIO; i++) begin
        if (CntW'(i) == slot) pack_d[i] = fifo_rddata;
      end
    end
    pack_cnt_d = slot + CntW'(inflight_q);

    m_valid_d = m_valid_q && !m_ready;
    m_data_d  = m_data_q;
    m_cnt_d   = m_cnt_q;
    if (emit) begin
      m_valid_d = 1'b1;
      m_data_d  = pack_q;
      m_cnt_d   = pack_cnt_q;
    end

    state_d = state_q;
    unique case (state_q)
      StRun: begin
        if (flush) state_d = StFlush;
      end
      StFlush: begin
        if (!inflight_q && ((pack_cnt_q == '0) || out_free)) state_d = StRun;
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q    <= StRun;
      pack_q     <= '0;
      pack_cnt_q <= '0;
      inflight_q <= 1'b0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      m_cnt_q    <= '0;
    end else begin
      state_q    <= state_d;
      pack_q     <= pack_d;
      pack_cnt_q <= pack_cnt_d;
      inflight_q <= inflight_d;
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
      m_cnt_q    <= m_cnt_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_cnt   = m_cnt_q;
  assign busy    = inflight_q || (pack_cnt_q != '0) || m_valid_q || (state_q != StRun);

endmodule
